// File: rtl/skdbf_tx.sv
// Transmit-side register slice: IP beats pass through an output register plus a
// one-entry skid register so both bus-facing outputs and IP busy come from flops.
module skdbf_tx #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          flush_i,
  input  logic [DW-1:0] ip_data_i,
  input  logic          ip_vld_i,
  output logic          registered_busy_o,
  output logic [DW-1:0] bus_data_o,
  output logic          bus_vld_o,
  input  logic          combinational_busy_i,
  output logic [1:0]    occupancy_o,
  output logic [1:0]    state_dbg_o
);

  // Handshake: a beat moves on a side when its valid is high and that side's busy
  // is low in the same cycle; while valid & busy the sender holds valid and data.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] skd_q, skd_d;
  logic          vld_q, busy_q;
  logic [1:0]    occ_q;
  logic          accept, drain;

  assign accept = ip_vld_i & ~busy_q;
  assign drain  = vld_q & ~combinational_busy_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skd_d   = skd_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_HALF;
          out_d   = ip_data_i;
        end
      end
      ST_HALF: begin
        if (accept && drain) begin
          out_d = ip_data_i;
        end else if (accept) begin
          state_d = ST_FULL;
          skd_d   = ip_data_i;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_d = ST_HALF;
          out_d   = skd_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // A flushed cycle still lets a drain complete on the bus; stored beats are dropped.
    if (flush_i) begin
      state_d = ST_EMPTY;
    end
  end

  // Output flags are registered copies of the next state so no input reaches an output.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skd_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skd_q   <= skd_d;
      vld_q   <= (state_d != ST_EMPTY);
      busy_q  <= (state_d == ST_FULL);
      occ_q   <= (state_d == ST_FULL) ? 2'd2 : ((state_d == ST_HALF) ? 2'd1 : 2'd0);
    end
  end

  assign bus_data_o        = out_q;
  assign bus_vld_o         = vld_q;
  assign registered_busy_o = busy_q;
  assign occupancy_o       = occ_q;
  assign state_dbg_o       = state_q;

endmodule

// File: tb/tb_skdbf_tx.sv
// Bench for skdbf_tx: reset, streaming, vector table for stall/bubble/flush, and a
// random run checked against an in-order scoreboard.
module tb_skdbf_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          flush_i = 1'b0;
  logic [DW-1:0] ip_data_i = 8'hAA;
  logic          ip_vld_i = 1'b1;
  logic          registered_busy_o;
  logic [DW-1:0] bus_data_o;
  logic          bus_vld_o;
  logic          combinational_busy_i = 1'b0;
  logic [1:0]    occupancy_o;
  logic [1:0]    state_dbg_o;

  skdbf_tx #(.DW(DW)) dut (
    .clk_i                (clk),
    .reset_i              (reset_i),
    .flush_i              (flush_i),
    .ip_data_i            (ip_data_i),
    .ip_vld_i             (ip_vld_i),
    .registered_busy_o    (registered_busy_o),
    .bus_data_o           (bus_data_o),
    .bus_vld_o            (bus_vld_o),
    .combinational_busy_i (combinational_busy_i),
    .occupancy_o          (occupancy_o),
    .state_dbg_o          (state_dbg_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: push on accept, pop on drain, plus per-cycle invariants
  logic          prev_stall, prev_flush, prev_ipwait;
  logic [DW-1:0] prev_data, prev_ip_data;

  always @(negedge clk) begin
    if (reset_i) begin
      exp_q.delete();
      prev_stall  = 1'b0;
      prev_flush  = 1'b0;
      prev_ipwait = 1'b0;
      prev_data   = '0;
      prev_ip_data = '0;
    end else begin
      check("occ_invariant", 32'(occupancy_o), int'(bus_vld_o) + int'(registered_busy_o));
      if (prev_stall && !prev_flush) begin
        check("stall_vld", 32'(bus_vld_o), 32'd1);
        check("stall_data", 32'(bus_data_o), 32'(prev_data));
      end
      if (prev_ipwait) begin
        check("ip_hold", {23'd0, ip_vld_i, ip_data_i}, {23'd0, 1'b1, prev_ip_data});
      end
      if (bus_vld_o && !combinational_busy_i) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("sb_data", 32'(bus_data_o), 32'(exp_q.pop_front()));
      end
      if (flush_i) exp_q.delete();
      else if (ip_vld_i && !registered_busy_o) exp_q.push_back(ip_data_i);
      prev_stall   = bus_vld_o && combinational_busy_i;
      prev_flush   = flush_i;
      prev_data    = bus_data_o;
      prev_ipwait  = ip_vld_i && registered_busy_o;
      prev_ip_data = ip_data_i;
    end
  end

  // Vector table
  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          cb;
    logic          fl;
    logic          ev;
    logic          eb;
    logic [1:0]    eo;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic cb, input logic fl,
                     input logic ev, input logic eb, input logic [1:0] eo, input logic [7:0] ed);
    vec_t e;
    e.v = v; e.d = d; e.cb = cb; e.fl = fl;
    e.ev = ev; e.eb = eb; e.eo = eo; e.ed = ed;
    tbl.push_back(e);
  endtask

  // Driver: inputs change #1 after the edge, outputs checked on the falling edge
  task automatic drive(input logic v, input logic [7:0] d, input logic cb, input logic fl);
    @(posedge clk);
    #1;
    ip_vld_i = v;
    ip_data_i = d;
    combinational_busy_i = cb;
    flush_i = fl;
  endtask

  initial begin
    int budget;
    int accepted;
    logic acc;

    // Reset held two cycles with a beat offered
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_vld", 32'(bus_vld_o), 32'd0);
      check("rst_busy", 32'(registered_busy_o), 32'd0);
      check("rst_occ", 32'(occupancy_o), 32'd0);
      check("rst_data", 32'(bus_data_o), 32'd0);
    end
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    ip_vld_i = 1'b0;
    @(negedge clk);
    check("post_rst_vld", 32'(bus_vld_o), 32'd0);
    check("post_rst_occ", 32'(occupancy_o), 32'd0);
    check("post_rst_data", 32'(bus_data_o), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("no_beat_vld", 32'(bus_vld_o), 32'd0);

    // Streaming 0x01..0x10
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i + 1), 1'b0, 1'b0);
      @(negedge clk);
      check("str_busy", 32'(registered_busy_o), 32'd0);
      if (i == 0) begin
        check("str_vld0", 32'(bus_vld_o), 32'd0);
      end else begin
        check("str_vld", 32'(bus_vld_o), 32'd1);
        check("str_occ", 32'(occupancy_o), 32'd1);
        check("str_data", 32'(bus_data_o), 32'(i));
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("str_last", 32'(bus_data_o), 32'h10);
    check("str_last_vld", 32'(bus_vld_o), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("str_end_vld", 32'(bus_vld_o), 32'd0);

    // Stall absorb
    add(1, 8'h20, 0, 0,  0, 0, 0, 8'h00);
    add(1, 8'h21, 1, 0,  1, 0, 1, 8'h20);
    add(1, 8'h22, 1, 0,  1, 1, 2, 8'h20);
    add(1, 8'h22, 1, 0,  1, 1, 2, 8'h20);
    add(1, 8'h22, 0, 0,  1, 1, 2, 8'h20);
    add(1, 8'h22, 0, 0,  1, 0, 1, 8'h21);
    add(0, 8'h00, 0, 0,  1, 0, 1, 8'h22);
    add(0, 8'h00, 0, 0,  0, 0, 0, 8'h00);
    // Bubble: single beat, then empty
    add(1, 8'h55, 0, 0,  0, 0, 0, 8'h00);
    add(0, 8'h00, 0, 0,  1, 0, 1, 8'h55);
    add(0, 8'h00, 0, 0,  0, 0, 0, 8'h00);
    add(0, 8'h00, 0, 0,  0, 0, 0, 8'h00);
    // Flush in FULL; first beat also accepted from EMPTY under bus busy
    add(1, 8'h30, 1, 0,  0, 0, 0, 8'h00);
    add(1, 8'h31, 1, 0,  1, 0, 1, 8'h30);
    add(1, 8'h32, 1, 1,  1, 1, 2, 8'h30);
    add(1, 8'h32, 0, 0,  0, 0, 0, 8'h00);
    add(0, 8'h00, 0, 0,  1, 0, 1, 8'h32);
    add(0, 8'h00, 0, 0,  0, 0, 0, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].cb, tbl[i].fl);
      @(negedge clk);
      check("tbl_vld", 32'(bus_vld_o), 32'(tbl[i].ev));
      check("tbl_busy", 32'(registered_busy_o), 32'(tbl[i].eb));
      check("tbl_occ", 32'(occupancy_o), 32'(tbl[i].eo));
      if (tbl[i].ev) check("tbl_data", 32'(bus_data_o), 32'(tbl[i].ed));
    end

    // Random: 10k accepted beats, 50% valid and 50% bus busy
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    accepted = 0;
    budget = 60000;
    while (accepted < 10000 && budget > 0) begin
      @(negedge clk);
      acc = ip_vld_i && !registered_busy_o;
      if (acc) accepted++;
      @(posedge clk);
      #1;
      if (acc || !ip_vld_i) begin
        ip_vld_i = 1'($urandom_range(0, 1));
        ip_data_i = 8'($urandom_range(0, 255));
      end
      combinational_busy_i = 1'($urandom_range(0, 1));
      budget--;
    end
    check("rand_budget", 32'(accepted >= 10000), 32'd1);

    // Drain remaining beats
    ip_vld_i = 1'b0;
    combinational_busy_i = 1'b0;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(negedge clk);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    check("final_vld", 32'(bus_vld_o), 32'd0);
    check("final_occ", 32'(occupancy_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
